// File: rtl/earom_ioctl_bridge.sv
// Shadow RAM for the Black Widow EAROM, restored from and saved to the HPS over ioctl.
// Game CPU writes that arrive during a transfer are held in a one-entry buffer until FLUSH.
module earom_ioctl_bridge #(
    parameter int          AW       = 6,
    parameter logic [7:0]  NV_INDEX = 8'd4
) (
    input  logic          clk_25,
    input  logic          RESET_L,
    input  logic          ioctl_download,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic [7:0]    ioctl_din,
    input  logic [AW-1:0] game_addr,
    input  logic          game_we,
    input  logic [7:0]    game_din,
    output logic [7:0]    game_dout,
    output logic          busy,
    output logic          dirty,
    output logic          overflow
);

    typedef enum logic [1:0] {IDLE, DOWNLOAD, UPLOAD, FLUSH} state_t;

    state_t          state;
    logic [7:0]      mem [2**AW];

    logic            sel;
    logic            addr_ok;
    logic            hps_wr;
    logic            commit;
    logic            game_direct;
    logic            transferring;

    logic            pend_valid;
    logic [AW-1:0]   pend_addr;
    logic [7:0]      pend_data;

    logic            rd_valid;
    logic [7:0]      rd_data;

    assign sel          = (ioctl_index == NV_INDEX);
    assign addr_ok      = (ioctl_addr[24:AW] == '0);
    assign transferring = (state == DOWNLOAD) || (state == UPLOAD);
    assign hps_wr       = (state == DOWNLOAD) && ioctl_wr && addr_ok;
    assign commit       = (state == FLUSH) && pend_valid;
    assign game_direct  = game_we && ((state == IDLE) || (state == FLUSH));

    // The game write is issued after the buffered commit so it wins on an address clash.
    always_ff @(posedge clk_25) begin
        if (commit)
            mem[pend_addr] <= pend_data;
        else if (hps_wr)
            mem[ioctl_addr[AW-1:0]] <= ioctl_dout;
        if (game_direct)
            mem[game_addr] <= game_din;
    end

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            state      <= IDLE;
            busy       <= 1'b0;
            dirty      <= 1'b0;
            overflow   <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= 8'h00;
        end else begin
            if (transferring && game_we) begin
                pend_valid <= 1'b1;
                pend_addr  <= game_addr;
                pend_data  <= game_din;
                if (pend_valid)
                    overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (game_we)
                        dirty <= 1'b1;
                    if (ioctl_download && sel) begin
                        state <= DOWNLOAD;
                        busy  <= 1'b1;
                    end else if (ioctl_upload && sel) begin
                        state <= UPLOAD;
                        busy  <= 1'b1;
                    end
                end
                DOWNLOAD: begin
                    if (!ioctl_download) begin
                        state <= FLUSH;
                        busy  <= 1'b0;
                        dirty <= 1'b0;
                    end
                end
                UPLOAD: begin
                    if (!ioctl_upload) begin
                        state <= FLUSH;
                        busy  <= 1'b0;
                        dirty <= 1'b0;
                    end
                end
                FLUSH: begin
                    state      <= IDLE;
                    pend_valid <= 1'b0;
                    if (pend_valid || game_we)
                        dirty <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage upload read: address captured with the strobe, data presented one cycle later.
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            rd_valid  <= 1'b0;
            rd_data   <= 8'h00;
            ioctl_din <= 8'h00;
            game_dout <= 8'h00;
        end else begin
            rd_valid  <= (state == UPLOAD) && ioctl_rd;
            rd_data   <= addr_ok ? mem[ioctl_addr[AW-1:0]] : 8'hFF;
            if (rd_valid)
                ioctl_din <= rd_data;
            game_dout <= mem[game_addr];
        end
    end

endmodule

// File: tb/tb_earom_ioctl_bridge.sv
// Directed bench for earom_ioctl_bridge: transfers, out-of-range accesses, game write buffering and reset.
module tb_earom_ioctl_bridge;

    logic        clk_25;
    logic        RESET_L;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic [5:0]  game_addr;
    logic        game_we;
    logic [7:0]  game_din;
    logic [7:0]  game_dout;
    logic        busy;
    logic        dirty;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    earom_ioctl_bridge #(.AW(6), .NV_INDEX(8'd4)) dut (
        .clk_25         (clk_25),
        .RESET_L        (RESET_L),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_rd       (ioctl_rd),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_din      (ioctl_din),
        .game_addr      (game_addr),
        .game_we        (game_we),
        .game_din       (game_din),
        .game_dout      (game_dout),
        .busy           (busy),
        .dirty          (dirty),
        .overflow       (overflow)
    );

    initial begin
        clk_25 = 1'b0;
        forever #20 clk_25 = ~clk_25;
    end

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk_25);
        #1;
    endtask

    task automatic hps_begin(input logic up, input logic [7:0] idx);
        ioctl_index = idx;
        if (up) ioctl_upload = 1'b1;
        else    ioctl_download = 1'b1;
        tick();
    endtask

    // Drop the level, then let FLUSH run and return to IDLE.
    task automatic hps_end;
        ioctl_upload   = 1'b0;
        ioctl_download = 1'b0;
        tick();
        tick();
    endtask

    task automatic hps_write(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic hps_read(input logic [24:0] a, output logic [7:0] d);
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        tick();
        ioctl_rd   = 1'b0;
        tick();
        d = ioctl_din;
    endtask

    task automatic game_write(input logic [5:0] a, input logic [7:0] d);
        game_we   = 1'b1;
        game_addr = a;
        game_din  = d;
        tick();
        game_we   = 1'b0;
    endtask

    task automatic game_read(input logic [5:0] a, output logic [7:0] d);
        game_addr = a;
        tick();
        d = game_dout;
    endtask

    task automatic test_reset;
        RESET_L        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_rd       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'h00;
        game_addr      = '0;
        game_we        = 1'b0;
        game_din       = 8'h00;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (dirty !== 1'b0) begin failures++; $display("[TB] FAIL reset_dirty: got %b expected 0", dirty); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        checks++;
        if (ioctl_din !== 8'h00) begin failures++; $display("[TB] FAIL reset_ioctl_din: got %h expected 00", ioctl_din); end
        checks++;
        if (game_dout !== 8'h00) begin failures++; $display("[TB] FAIL reset_game_dout: got %h expected 00", game_dout); end
        RESET_L = 1'b1;
        tick();
    endtask

    task automatic test_download_upload;
        logic [7:0] d;
        game_write(6'h3F, 8'hEE);
        checks++;
        if (dirty !== 1'b1) begin failures++; $display("[TB] FAIL pre_dl_dirty: got %b expected 1", dirty); end
        hps_begin(1'b0, 8'd4);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL dl_busy: got %b expected 1", busy); end
        for (int i = 0; i < 64; i++) hps_write(25'(i), 8'(i));
        hps_end();
        checks++;
        if (dirty !== 1'b0) begin failures++; $display("[TB] FAIL dl_end_dirty: got %b expected 0", dirty); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL dl_end_busy: got %b expected 0", busy); end
        game_read(6'h3F, d);
        checks++;
        if (d !== 8'h3F) begin failures++; $display("[TB] FAIL dl_ram_3f: got %h expected 3f", d); end
        hps_begin(1'b1, 8'd4);
        hps_read(25'h05, d);
        checks++;
        if (d !== 8'h05) begin failures++; $display("[TB] FAIL ul_addr_05: got %h expected 05", d); end
        hps_end();
        checks++;
        if (dirty !== 1'b0) begin failures++; $display("[TB] FAIL ul_end_dirty: got %b expected 0", dirty); end
    endtask

    task automatic test_out_of_range;
        logic [7:0] d;
        hps_begin(1'b1, 8'd4);
        hps_read(25'h40, d);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("[TB] FAIL ul_addr_40: got %h expected ff", d); end
        hps_read(25'h07, d);
        checks++;
        if (d !== 8'h07) begin failures++; $display("[TB] FAIL ul_addr_07: got %h expected 07", d); end
        hps_read(25'h1FF, d);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("[TB] FAIL ul_addr_1ff: got %h expected ff", d); end
        hps_end();
        hps_begin(1'b0, 8'd4);
        hps_write(25'h41, 8'hAA);
        hps_end();
        game_read(6'h01, d);
        checks++;
        if (d !== 8'h01) begin failures++; $display("[TB] FAIL dl_no_alias_01: got %h expected 01", d); end
    endtask

    task automatic test_idle_game_write;
        logic [7:0] d;
        game_write(6'h10, 8'h5A);
        checks++;
        if (dirty !== 1'b1) begin failures++; $display("[TB] FAIL idle_we_dirty: got %b expected 1", dirty); end
        hps_begin(1'b1, 8'd4);
        hps_read(25'h10, d);
        checks++;
        if (d !== 8'h5A) begin failures++; $display("[TB] FAIL ul_addr_10: got %h expected 5a", d); end
        hps_end();
        checks++;
        if (dirty !== 1'b0) begin failures++; $display("[TB] FAIL ul_clear_dirty: got %b expected 0", dirty); end
    endtask

    task automatic test_overflow;
        logic [7:0] d;
        hps_begin(1'b1, 8'd4);
        game_write(6'h20, 8'h11);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_first: got %b expected 0", overflow); end
        game_write(6'h21, 8'h22);
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_second: got %b expected 1", overflow); end
        game_read(6'h21, d);
        checks++;
        if (d !== 8'h21) begin failures++; $display("[TB] FAIL busy_ram_21: got %h expected 21", d); end
        checks++;
        if (dirty !== 1'b0) begin failures++; $display("[TB] FAIL busy_dirty: got %b expected 0", dirty); end
        hps_end();
        checks++;
        if (dirty !== 1'b1) begin failures++; $display("[TB] FAIL flush_dirty: got %b expected 1", dirty); end
        game_read(6'h21, d);
        checks++;
        if (d !== 8'h22) begin failures++; $display("[TB] FAIL flush_ram_21: got %h expected 22", d); end
        game_read(6'h20, d);
        checks++;
        if (d !== 8'h20) begin failures++; $display("[TB] FAIL flush_ram_20: got %h expected 20", d); end
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        hps_begin(1'b0, 8'd0);
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rom_busy: got %b expected 0", busy); end
        hps_write(25'h03, 8'hEE);
        hps_end();
        game_read(6'h03, d);
        checks++;
        if (d !== 8'h03) begin failures++; $display("[TB] FAIL rom_ram_03: got %h expected 03", d); end
        hps_begin(1'b1, 8'd4);
        ioctl_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ioctl_addr = 25'(i);
            tick();
            checks++;
            if (i == 0) begin
                if (ioctl_din !== 8'h5A) begin failures++; $display("[TB] FAIL b2b_hold: got %h expected 5a", ioctl_din); end
            end else begin
                if (ioctl_din !== 8'(i - 1)) begin failures++; $display("[TB] FAIL b2b_%0d: got %h expected %h", i - 1, ioctl_din, 8'(i - 1)); end
            end
        end
        ioctl_rd = 1'b0;
        tick();
        checks++;
        if (ioctl_din !== 8'h03) begin failures++; $display("[TB] FAIL b2b_3: got %h expected 03", ioctl_din); end
        hps_end();
    endtask

    task automatic test_reset_mid_download;
        logic [7:0] d;
        hps_begin(1'b0, 8'd4);
        for (int i = 0; i < 10; i++) hps_write(25'(i), 8'(8'h80 + i));
        game_write(6'h30, 8'h77);
        RESET_L = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_overflow: got %b expected 0", overflow); end
        ioctl_download = 1'b0;
        tick();
        RESET_L = 1'b1;
        tick();
        game_read(6'h00, d);
        checks++;
        if (d !== 8'h80) begin failures++; $display("[TB] FAIL rst_ram_00: got %h expected 80", d); end
        game_read(6'h09, d);
        checks++;
        if (d !== 8'h89) begin failures++; $display("[TB] FAIL rst_ram_09: got %h expected 89", d); end
        game_read(6'h0A, d);
        checks++;
        if (d !== 8'h0A) begin failures++; $display("[TB] FAIL rst_ram_0a: got %h expected 0a", d); end
        tick();
        game_read(6'h30, d);
        checks++;
        if (d !== 8'h30) begin failures++; $display("[TB] FAIL rst_pend_dropped: got %h expected 30", d); end
        game_write(6'h3E, 8'h99);
        checks++;
        if (dirty !== 1'b1) begin failures++; $display("[TB] FAIL rst_idle_dirty: got %b expected 1", dirty); end
    endtask

    initial begin
        test_reset();
        test_download_upload();
        test_out_of_range();
        test_idle_game_write();
        test_overflow();
        test_back_to_back();
        test_reset_mid_download();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
